and_event_counter: RTL

Downstream stage for the 2-input AND gate output: synchronizes the gate's 1-bit result into the `clk` domain, rejects high pulses shorter than a minimum width, and counts qualified rising events. Outputs are a per-event strobe, a wrapping event count, a sticky threshold-reached flag and a sticky overflow flag. It is the first sequential consumer of gate-level logic in the design and drives status LEDs/counters on the board.

---
 rtl/and_event_counter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/and_event_counter.sv
// -----------------------------------------------------------------------------
// and_event_counter
//
// Takes the 1-bit output of the 2-input AND gate and synchronizes it into
// the clk domain. It rejects high pulses shorter than MIN_HIGH synchronized
// samples and counts each qualified rising event.
//
// Parameters:
//   WIDTH       - event counter width
//   SYNC_STAGES - synchronizer flops (>= 2)
//   MIN_HIGH    - consecutive synchronized high samples needed per event (>= 1)
//   THRESH      - count value that sets the sticky hit flag
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   in    - AND gate output, may be asynchronous to clk
//   en    - count enable; a qualified event seen while low is dropped
//   clear - synchronous clear of count/pulse/hit/ovf; wins over an event
//   count - wrapping count of qualified events
//   pulse - one-cycle strobe per counted event
//   hit   - sticky, set when count becomes THRESH
//   ovf   - sticky, set when count wraps from all-ones to zero
// -----------------------------------------------------------------------------
module and_event_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_HIGH    = 3,
    parameter int unsigned THRESH      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             pulse,
    output logic             hit,
    output logic             ovf
);

    localparam int unsigned      HW         = $clog2(MIN_HIGH + 1);
    localparam logic [HW-1:0]    MIN_HIGH_V = HW'(MIN_HIGH);
    localparam logic [WIDTH-1:0] THRESH_V   = WIDTH'(THRESH);

    typedef enum logic [1:0] {
        LOW,
        ARM,
        HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [HW-1:0]          hcnt_inc;
    logic                   event_raw;
    logic [WIDTH-1:0]       count_inc;

    // Input synchronizer; only the last stage is observed by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign hcnt_inc = hcnt_q + HW'(1);

    // An event is raised once per high period, on the transition into HIGH.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        event_raw = 1'b0;
        unique case (state_q)
            LOW: begin
                if (s) begin
                    if (MIN_HIGH == 1) begin
                        state_d   = HIGH;
                        hcnt_d    = MIN_HIGH_V;
                        event_raw = 1'b1;
                    end else begin
                        state_d = ARM;
                        hcnt_d  = HW'(1);
                    end
                end
            end
            ARM: begin
                if (!s) begin
                    state_d = LOW;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc == MIN_HIGH_V) begin
                        state_d   = HIGH;
                        event_raw = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = LOW;
                    hcnt_d  = '0;
                end
            end
            default: begin
                state_d = LOW;
                hcnt_d  = '0;
            end
        endcase
    end

    assign count_inc = count + WIDTH'(1);

    // Event handling; clear has priority and swallows a coincident event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            pulse <= 1'b0;
            hit   <= 1'b0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            pulse <= 1'b0;
            hit   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            pulse <= event_raw && en;
            if (event_raw && en) begin
                count <= count_inc;
                if (&count) begin
                    ovf <= 1'b1;
                end
                if (count_inc == THRESH_V) begin
                    hit <= 1'b1;
                end
            end
        end
    end

endmodule
